// File: rtl/memory_access_unit_pkg.sv
// Shared types for the memory-access stage: operation codes, funct3
// widths, exception codes and the stage FSM encoding.
package memory_access_unit_pkg;

    typedef enum logic [4:0] {
        NOP    = 5'd0,
        ADD    = 5'd1,
        SUB    = 5'd2,
        LOGIC  = 5'd3,
        SHIFT  = 5'd4,
        BRANCH = 5'd5,
        LOAD   = 5'd8,
        STORE  = 5'd9
    } operation_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LD  = 3'd3,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5,
        F3_LWU = 3'd6
    } funct3_load_t;

    typedef enum logic [2:0] {
        F3_SB = 3'd0,
        F3_SH = 3'd1,
        F3_SW = 3'd2,
        F3_SD = 3'd3
    } funct3_store_t;

    typedef enum logic [1:0] {
        EXC_NONE       = 2'd0,
        EXC_MISALIGNED = 2'd1,
        EXC_TIMEOUT    = 2'd2,
        EXC_ILLEGAL    = 2'd3
    } mem_exc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } mau_state_t;

    function automatic logic is_mem_op(logic [4:0] op);
        return (op == LOAD) || (op == STORE);
    endfunction

endpackage

// File: rtl/memory_access_unit_mem_lane_align.sv
// Combinational lane unit: byte mask, replicated store data, load extract.
// Ports: funct3/addr_lo in; mask, cmd_data, load_data, misaligned, illegal out.
module mem_lane_align #(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [2:0]        addr_lo,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   rsp_data,
    output logic [XLEN/8-1:0] mask,
    output logic [XLEN-1:0]   cmd_data,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned,
    output logic              illegal
);
    import memory_access_unit_pkg::*;

    localparam int MW   = XLEN / 8;
    localparam int OFFW = $clog2(MW);

    logic [OFFW-1:0] off;
    logic [XLEN-1:0] sh;

    assign off = addr_lo[OFFW-1:0];
    // Bring the addressed lane down to bit 0.
    assign sh  = rsp_data >> {off, 3'b000};

    assign illegal = (funct3 == 3'd7) ||
                     ((XLEN == 32) && (funct3 == 3'd3 || funct3 == 3'd6));

    always_comb begin
        mask       = '1;
        cmd_data   = store_data;
        misaligned = 1'b0;
        unique case (funct3[1:0])
            2'd0: begin
                mask     = MW'(1) << off;
                cmd_data = {MW{store_data[7:0]}};
            end
            2'd1: begin
                mask       = MW'(3) << off;
                cmd_data   = {(XLEN/16){store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            2'd2: begin
                mask       = MW'(15) << off;
                cmd_data   = {(XLEN/32){store_data[31:0]}};
                misaligned = addr_lo[1:0] != 2'd0;
            end
            default: begin
                mask       = '1;
                cmd_data   = store_data;
                misaligned = addr_lo != 3'd0;
            end
        endcase
    end

    always_comb begin
        load_data = sh;
        unique case (funct3)
            F3_LB:   load_data = XLEN'($signed(sh[7:0]));
            F3_LH:   load_data = XLEN'($signed(sh[15:0]));
            F3_LW:   load_data = XLEN'($signed(sh[31:0]));
            F3_LBU:  load_data = XLEN'(sh[7:0]);
            F3_LHU:  load_data = XLEN'(sh[15:0]);
            F3_LWU:  load_data = XLEN'(sh[31:0]);
            default: load_data = sh;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Registered memory-access stage owning the data-bus handshake.
// Ports: t_* upstream, i_* downstream, dbus_cmd_*/dbus_rsp_* data bus.
module memory_access_unit #(
    parameter int XLEN        = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstf,
    input  logic [31:0]       t_instr,
    input  logic [31:0]       t_pc,
    input  logic [4:0]        t_op,
    input  logic [XLEN-1:0]   t_alu,
    input  logic [XLEN-1:0]   t_rs2,
    input  logic              t_valid,
    output logic              t_ready,
    output logic [31:0]       i_instr,
    output logic [31:0]       i_pc,
    output logic [4:0]        i_op,
    output logic [XLEN-1:0]   i_result,
    output logic [1:0]        i_exc,
    output logic              i_valid,
    input  logic              i_ready,
    output logic [XLEN-1:0]   dbus_cmd_addr,
    output logic [XLEN-1:0]   dbus_cmd_data,
    output logic [XLEN/8-1:0] dbus_cmd_mask,
    output logic              dbus_cmd_we,
    output logic              dbus_cmd_valid,
    input  logic              dbus_cmd_ready,
    input  logic [XLEN-1:0]   dbus_rsp_data,
    input  logic              dbus_rsp_valid
);
    import memory_access_unit_pkg::*;

    localparam int MW = XLEN / 8;
    localparam logic [15:0] TO_LAST = 16'(RSP_TIMEOUT - 1);

    mau_state_t state, state_next;

    logic [31:0]     p_instr, p_pc;
    logic [4:0]      p_op;
    logic [XLEN-1:0] p_alu;
    logic [2:0]      p_f3, p_lo;
    logic [15:0]     cnt;
    logic            orphan;

    logic [2:0]      lane_f3, lane_lo;
    logic [MW-1:0]   lane_mask;
    logic [XLEN-1:0] lane_wdata, lane_rdata;
    logic            lane_mis, lane_ill;

    logic            out_load, out_pend, cmd_load;
    logic            cnt_clr, orphan_set;
    logic [XLEN-1:0] out_result;
    mem_exc_t        out_exc;

    assign t_ready = !rstf && (state == IDLE) && (!i_valid || i_ready);
    assign dbus_cmd_valid = (state == CMD);

    // The lane unit decodes the incoming op in IDLE, the held op otherwise.
    assign lane_f3 = (state == IDLE) ? t_instr[14:12] : p_f3;
    assign lane_lo = (state == IDLE) ? t_alu[2:0] : p_lo;

    mem_lane_align #(.XLEN(XLEN)) u_lane (
        .funct3     (lane_f3),
        .addr_lo    (lane_lo),
        .store_data (t_rs2),
        .rsp_data   (dbus_rsp_data),
        .mask       (lane_mask),
        .cmd_data   (lane_wdata),
        .load_data  (lane_rdata),
        .misaligned (lane_mis),
        .illegal    (lane_ill)
    );

    always_ff @(posedge clk) begin
        if (rstf) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        out_load   = 1'b0;
        out_pend   = 1'b0;
        out_result = '0;
        out_exc    = EXC_NONE;
        cmd_load   = 1'b0;
        cnt_clr    = 1'b0;
        orphan_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (t_valid && t_ready) begin
                    if (!is_mem_op(t_op)) begin
                        out_load   = 1'b1;
                        out_result = t_alu;
                    end else if (lane_ill) begin
                        out_load   = 1'b1;
                        out_result = t_alu;
                        out_exc    = EXC_ILLEGAL;
                    end else if (lane_mis) begin
                        out_load   = 1'b1;
                        out_result = t_alu;
                        out_exc    = EXC_MISALIGNED;
                    end else begin
                        cmd_load   = 1'b1;
                        state_next = CMD;
                    end
                end
            end
            CMD: begin
                if (dbus_cmd_ready) begin
                    if (dbus_cmd_we) begin
                        out_load   = 1'b1;
                        out_pend   = 1'b1;
                        out_result = p_alu;
                        state_next = IDLE;
                    end else begin
                        cnt_clr    = 1'b1;
                        state_next = RSP;
                    end
                end
            end
            RSP: begin
                // A response arriving on the expiry cycle still wins.
                if (dbus_rsp_valid) begin
                    out_load   = 1'b1;
                    out_pend   = 1'b1;
                    out_result = lane_rdata;
                    state_next = IDLE;
                end else if (cnt == TO_LAST) begin
                    out_load   = 1'b1;
                    out_pend   = 1'b1;
                    out_exc    = EXC_TIMEOUT;
                    orphan_set = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstf) begin
            i_valid       <= 1'b0;
            i_instr       <= '0;
            i_pc          <= '0;
            i_op          <= '0;
            i_result      <= '0;
            i_exc         <= '0;
            p_instr       <= '0;
            p_pc          <= '0;
            p_op          <= '0;
            p_alu         <= '0;
            p_f3          <= '0;
            p_lo          <= '0;
            dbus_cmd_addr <= '0;
            dbus_cmd_data <= '0;
            dbus_cmd_mask <= '0;
            dbus_cmd_we   <= 1'b0;
            cnt           <= '0;
            orphan        <= 1'b0;
        end else begin
            if (out_load) begin
                i_valid  <= 1'b1;
                i_result <= out_result;
                i_exc    <= out_exc;
                i_instr  <= out_pend ? p_instr : t_instr;
                i_pc     <= out_pend ? p_pc : t_pc;
                i_op     <= out_pend ? p_op : t_op;
            end else if (i_ready) begin
                i_valid <= 1'b0;
            end
            if (cmd_load) begin
                p_instr       <= t_instr;
                p_pc          <= t_pc;
                p_op          <= t_op;
                p_alu         <= t_alu;
                p_f3          <= t_instr[14:12];
                p_lo          <= t_alu[2:0];
                dbus_cmd_addr <= t_alu & ~XLEN'(MW - 1);
                dbus_cmd_data <= lane_wdata;
                dbus_cmd_mask <= lane_mask;
                dbus_cmd_we   <= (t_op == STORE);
            end
            if (cnt_clr)           cnt <= '0;
            else if (state == RSP) cnt <= cnt + 16'd1;
            // A stale reply after a timeout is swallowed once.
            if (orphan_set)
                orphan <= 1'b1;
            else if (orphan && state != RSP && dbus_rsp_valid)
                orphan <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit (XLEN=32, RSP_TIMEOUT=4).
// Directed steps plus randomized ops against a byte-level memory model.
module tb_memory_access_unit;
    import memory_access_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic        clk = 1'b0;
    logic        rstf;
    logic [31:0] t_instr, t_pc, t_alu, t_rs2;
    logic [4:0]  t_op;
    logic        t_valid, t_ready;
    logic [31:0] i_instr, i_pc, i_result;
    logic [4:0]  i_op;
    logic [1:0]  i_exc;
    logic        i_valid, i_ready;
    logic [31:0] dbus_cmd_addr, dbus_cmd_data, dbus_rsp_data;
    logic [3:0]  dbus_cmd_mask;
    logic        dbus_cmd_we, dbus_cmd_valid, dbus_cmd_ready;
    logic        dbus_rsp_valid;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [int unsigned];

    always #5 clk = ~clk;

    memory_access_unit #(.XLEN(XLEN), .RSP_TIMEOUT(TO)) dut (
        .clk(clk), .rstf(rstf),
        .t_instr(t_instr), .t_pc(t_pc), .t_op(t_op),
        .t_alu(t_alu), .t_rs2(t_rs2),
        .t_valid(t_valid), .t_ready(t_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_op(i_op),
        .i_result(i_result), .i_exc(i_exc),
        .i_valid(i_valid), .i_ready(i_ready),
        .dbus_cmd_addr(dbus_cmd_addr), .dbus_cmd_data(dbus_cmd_data),
        .dbus_cmd_mask(dbus_cmd_mask), .dbus_cmd_we(dbus_cmd_we),
        .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
        .dbus_rsp_data(dbus_rsp_data), .dbus_rsp_valid(dbus_rsp_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int unsigned wa);
        if (mem.exists(wa)) return mem[wa];
        return wa * 32'h9E37_79B1;
    endfunction

    function automatic int ref_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] ref_fault(input logic [2:0] f3,
                                             input logic [31:0] a);
        if (f3 == 3'd7 || f3 == 3'd3 || f3 == 3'd6) return 2'd3;
        if ((a % ref_size(f3)) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [3:0] m;
        m = '0;
        for (int b = 0; b < 4; b++)
            if (b >= int'(off) && b < int'(off) + ref_size(f3)) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3,
                                              input logic [31:0] d);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = d[8*(b % ref_size(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] a);
        logic [31:0] w, v;
        int sz, off;
        w = mem_rd(a >> 2);
        sz = ref_size(f3);
        off = int'(a % 4);
        v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
        if (f3 < 3'd4 && v[8*sz-1])
            for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Entered and left at a falling edge; i_ready is held high.
    task automatic do_op(input logic [4:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2,
                         input int cmd_d, input int rsp_d);
        logic [31:0] instr, pc, exp_res, ed, w;
        logic [3:0]  em;
        logic [1:0]  exp_exc;
        logic        mop;
        instr = $urandom;
        instr[14:12] = f3;
        pc = $urandom & ~32'h3;
        mop = (op == LOAD) || (op == STORE);
        exp_exc = mop ? ref_fault(f3, a) : 2'd0;
        exp_res = a;
        em = ref_mask(f3, a[1:0]);
        ed = ref_wdata(f3, rs2);
        t_valid = 1'b1; t_instr = instr; t_pc = pc;
        t_op = op; t_alu = a; t_rs2 = rs2;
        #1 check("t_ready", 64'(t_ready), 64'(1));
        @(posedge clk); @(negedge clk);
        t_valid = 1'b0;
        dbus_rsp_valid = 1'b0;
        if (mop && exp_exc == 2'd0) begin
            check("cmd_valid", 64'(dbus_cmd_valid), 64'(1));
            check("cmd_addr", 64'(dbus_cmd_addr), 64'(a & ~32'h3));
            check("cmd_mask", 64'(dbus_cmd_mask), 64'(em));
            check("cmd_we", 64'(dbus_cmd_we), 64'(op == STORE));
            if (op == STORE) check("cmd_data", 64'(dbus_cmd_data), 64'(ed));
            repeat (cmd_d) begin
                @(posedge clk); @(negedge clk);
                check("cmd_hold", 64'(dbus_cmd_valid), 64'(1));
                check("cmd_hold_addr", 64'(dbus_cmd_addr), 64'(a & ~32'h3));
                check("wait_ivalid", 64'(i_valid), 64'(0));
            end
            dbus_cmd_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            dbus_cmd_ready = 1'b0;
            if (op == STORE) begin
                w = mem_rd(a >> 2);
                for (int b = 0; b < 4; b++)
                    if (em[b]) w[8*b +: 8] = ed[8*b +: 8];
                mem[a >> 2] = w;
            end else begin
                for (int k = 1; k <= TO; k++) begin
                    dbus_rsp_data = $urandom;
                    if (k == rsp_d) begin
                        dbus_rsp_valid = 1'b1;
                        dbus_rsp_data = mem_rd(a >> 2);
                    end
                    @(posedge clk); @(negedge clk);
                    dbus_rsp_valid = 1'b0;
                    if (k == rsp_d || k == TO) break;
                    check("rsp_ivalid", 64'(i_valid), 64'(0));
                end
                if (rsp_d >= 1 && rsp_d <= TO) begin
                    exp_res = ref_load(f3, a);
                end else begin
                    exp_res = '0;
                    exp_exc = 2'd2;
                end
            end
        end
        check("i_valid", 64'(i_valid), 64'(1));
        check("i_result", 64'(i_result), 64'(exp_res));
        check("i_exc", 64'(i_exc), 64'(exp_exc));
        check("i_pc", 64'(i_pc), 64'(pc));
        check("i_instr", 64'(i_instr), 64'(instr));
        check("i_op", 64'(i_op), 64'(op));
        if (mop) check("cmd_idle", 64'(dbus_cmd_valid), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int kind;

        rstf = 1'b1; t_valid = 1'b0; t_instr = '0; t_pc = '0;
        t_op = '0; t_alu = '0; t_rs2 = '0; i_ready = 1'b1;
        dbus_cmd_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rsp_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ivalid", 64'(i_valid), 64'(0));
        check("rst_cmd_valid", 64'(dbus_cmd_valid), 64'(0));
        check("rst_tready", 64'(t_ready), 64'(0));
        check("rst_result", 64'(i_result), 64'(0));
        check("rst_mask", 64'(dbus_cmd_mask), 64'(0));
        rstf = 1'b0;
        #1 check("rst_release_tready", 64'(t_ready), 64'(1));
        @(negedge clk);

        // Back-to-back non-memory ops.
        do_op(ADD, 3'd0, 32'h1234, 32'h0, 0, 0);
        do_op(ADD, 3'd0, 32'hDEAD_BEEF, 32'h0, 0, 0);
        do_op(SUB, 3'd0, 32'h0000_0001, 32'h0, 0, 0);
        do_op(ADD, 3'd0, 32'hFFFF_FFFF, 32'h0, 0, 0);

        // SB with a slow command accept.
        do_op(STORE, 3'd0, 32'h1003, 32'h0000_00AB, 2, 0);
        check("sb_mem", 64'(mem_rd(32'h1000 >> 2) >> 24), 64'(8'hAB));

        // Signed and unsigned halfword from the upper lane.
        mem[32'h2000 >> 2] = 32'h8001_0000;
        do_op(LOAD, 3'd1, 32'h2002, 32'h0, 0, 1);
        check("lh_value", 64'(i_result), 64'(32'hFFFF_8001));
        do_op(LOAD, 3'd5, 32'h2002, 32'h0, 1, 2);
        check("lhu_value", 64'(i_result), 64'(32'h0000_8001));

        // Faulting accesses never reach the bus.
        do_op(LOAD, 3'd2, 32'h3001, 32'h0, 0, 0);
        do_op(LOAD, 3'd3, 32'h3000, 32'h0, 0, 0);
        do_op(STORE, 3'd7, 32'h3000, 32'h0, 0, 0);

        // Timeout, then a late reply during an ADD, then a good load.
        do_op(LOAD, 3'd2, 32'h4000, 32'h0, 0, 0);
        dbus_rsp_valid = 1'b1;
        dbus_rsp_data = 32'h5555_AAAA;
        do_op(ADD, 3'd0, 32'h77, 32'h0, 0, 0);
        mem[32'h4004 >> 2] = 32'h1357_9BDF;
        do_op(LOAD, 3'd2, 32'h4004, 32'h0, 0, 2);
        // Reply on the expiry cycle still wins.
        do_op(LOAD, 3'd0, 32'h4005, 32'h0, 0, TO);

        // Reset while waiting for a response, with the sink stalled.
        mem[32'h5000 >> 2] = 32'hCAFE_F00D;
        t_valid = 1'b1; t_op = LOAD; t_instr = 32'h0000_2003;
        t_alu = 32'h5000; t_pc = 32'h100;
        @(posedge clk); @(negedge clk);
        t_valid = 1'b0;
        dbus_cmd_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        dbus_cmd_ready = 1'b0;
        check("rsp_tready", 64'(t_ready), 64'(0));
        i_ready = 1'b0;
        rstf = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mid_rst_ivalid", 64'(i_valid), 64'(0));
        check("mid_rst_cmd_valid", 64'(dbus_cmd_valid), 64'(0));
        check("mid_rst_tready", 64'(t_ready), 64'(0));
        check("mid_rst_result", 64'(i_result), 64'(0));
        check("mid_rst_addr", 64'(dbus_cmd_addr), 64'(0));
        rstf = 1'b0;
        #1 check("mid_rst_release", 64'(t_ready), 64'(1));
        dbus_rsp_valid = 1'b1;
        dbus_rsp_data = 32'h1111_1111;
        @(posedge clk); @(negedge clk);
        dbus_rsp_valid = 1'b0;
        check("stale_rsp_ignored", 64'(i_valid), 64'(0));
        i_ready = 1'b1;
        do_op(LOAD, 3'd2, 32'h5000, 32'h0, 0, 1);

        // Randomized mix over a small shared window.
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 2));
            a = 32'h6000 + $urandom_range(0, 31);
            if (kind == 0) begin
                do_op(ADD, 3'd0, $urandom, 32'h0, 0, 0);
            end else if (kind == 1) begin
                f3 = 3'($urandom_range(0, 7));
                do_op(LOAD, f3, a, 32'h0, int'($urandom_range(0, 3)),
                      int'($urandom_range(1, TO + 1)));
            end else begin
                f3 = 3'($urandom_range(0, 3));
                do_op(STORE, f3, a, $urandom,
                      int'($urandom_range(0, 3)), 0);
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
